// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and default sizing for the truth-table sweeper.
// Imported by the interface, the comparator and the top.
package truth_sweep_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int N_FUNC_DEF = 3;
    localparam int SETTLE_DEF = 1;

    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

    localparam int N_VEC_DEF = n_vec(N_IN_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, result and function-block signals of the sweeper.
// The sweeper uses the slave side; the host and the checked block use the master side.
interface truth_table_sweeper_if
    import truth_sweep_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_FUNC = N_FUNC_DEF
);

    logic                           start;
    logic [N_IN-1:0]                vec;
    logic [N_FUNC-1:0]              f_in;
    logic [N_FUNC-1:0]              sop_in;
    logic [N_FUNC-1:0]              pos_in;
    logic                           busy;
    logic                           done;
    logic                           pass;
    logic [N_IN:0]                  err_count;
    logic [N_IN-1:0]                first_err_vec;
    logic                           first_err_valid;
    logic [N_FUNC*(1<<N_IN)-1:0]    tt_out;

    modport master (
        output start, f_in, sop_in, pos_in,
        input  vec, busy, done, pass, err_count, first_err_vec, first_err_valid, tt_out
    );

    modport slave (
        input  start, f_in, sop_in, pos_in,
        output vec, busy, done, pass, err_count, first_err_vec, first_err_valid, tt_out
    );

endinterface

// File: rtl/truth_table_sweeper_cmp.sv
// Per-function comparison of the canonical output against its SOP and POS forms.
module sweep_cmp
    import truth_sweep_pkg::*;
#(
    parameter int N_FUNC = N_FUNC_DEF
) (
    input  logic [N_FUNC-1:0] f_in,
    input  logic [N_FUNC-1:0] sop_in,
    input  logic [N_FUNC-1:0] pos_in,
    output logic [N_FUNC-1:0] mismatch_mask,
    output logic              mismatch
);

    assign mismatch_mask = (sop_in ^ f_in) | (pos_in ^ f_in);
    assign mismatch      = |mismatch_mask;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper that checks SOP/POS implementations against the canonical outputs.
// Optional truth-table capture into tt_out is built when TT_CAPTURE_EN is defined.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_FUNC = N_FUNC_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_sweeper_if.slave bus
);

    localparam int              N_VEC    = n_vec(N_IN);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(N_VEC - 1);
    localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [N_IN:0]       err_q, err_d;
    logic [N_IN-1:0]     fev_q, fev_d;
    logic                fevalid_q, fevalid_d;
    logic                pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept_s;
    logic                mismatch_s;
    logic [N_FUNC-1:0]   mismatch_mask_s;

`ifdef TT_CAPTURE_EN
    logic [N_FUNC-1:0][N_VEC-1:0] tt_q, tt_d;
`endif

    sweep_cmp #(.N_FUNC(N_FUNC)) u_cmp (
        .f_in          (bus.f_in),
        .sop_in        (bus.sop_in),
        .pos_in        (bus.pos_in),
        .mismatch_mask (mismatch_mask_s),
        .mismatch      (mismatch_s)
    );

    // start is honoured only when no sweep is running
    assign accept_s = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // next-state and result update logic
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fev_d     = fev_q;
        fevalid_d = fevalid_q;
        pass_d    = pass_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef TT_CAPTURE_EN
        tt_d      = tt_q;
`endif
        if (accept_s) begin
            state_d   = ST_WAIT;
            vec_d     = '0;
            cnt_d     = CNT_LOAD;
            err_d     = '0;
            fev_d     = '0;
            fevalid_d = 1'b0;
            pass_d    = 1'b0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
`ifdef TT_CAPTURE_EN
            tt_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        err_d = err_q + (N_IN+1)'(1);
                    end else begin
                        err_d = err_q;
                    end
                    if (mismatch_s && !fevalid_q) begin
                        fev_d     = vec_q;
                        fevalid_d = 1'b1;
                    end else begin
                        fev_d     = fev_q;
                    end
`ifdef TT_CAPTURE_EN
                    for (int i = 0; i < N_FUNC; i++) begin
                        tt_d[i][vec_q] = bus.f_in[i];
                    end
`endif
                    // the pass verdict must include the vector being checked right now
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = ST_WAIT;
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // state and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            cnt_q     <= 4'd0;
            err_q     <= '0;
            fev_q     <= '0;
            fevalid_q <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef TT_CAPTURE_EN
            tt_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            fev_q     <= fev_d;
            fevalid_q <= fevalid_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef TT_CAPTURE_EN
            tt_q      <= tt_d;
`endif
        end
    end

    assign bus.vec             = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = fev_q;
    assign bus.first_err_valid = fevalid_q;
`ifdef TT_CAPTURE_EN
    assign bus.tt_out          = tt_q;
`else
    assign bus.tt_out          = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: SETTLE=1 and SETTLE=3 instances beside a modelled function block.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(4), .N_FUNC(3)) bus1 ();
    truth_table_sweeper_if #(.N_IN(4), .N_FUNC(3)) bus3 ();

    truth_table_sweeper #(.N_IN(4), .N_FUNC(3), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    truth_table_sweeper #(.N_IN(4), .N_FUNC(3), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;   // 0 clean, 1 sop[1] bad at vec 5, 2 pos[2] always bad, 3 f = parity

    logic [2:0]  base1_s, base3_s;
    logic [47:0] tt_clean_exp;

    // returns {h,g,f}: f = A&B (or parity in mode 3), g = A|C, h = B^D
    function automatic logic [2:0] fn(input logic [3:0] v, input int m);
        logic a, b, c, d;
        logic [2:0] r;
        {a, b, c, d} = v;
        r[0] = (m == 3) ? (a ^ b ^ c ^ d) : (a & b);
        r[1] = a | c;
        r[2] = b ^ d;
        return r;
    endfunction

    always_comb begin
        base1_s     = fn(bus1.vec, mode);
        bus1.f_in   = base1_s;
        bus1.sop_in = base1_s ^ (((mode == 1) && (bus1.vec == 4'd5)) ? 3'b010 : 3'b000);
        bus1.pos_in = base1_s ^ ((mode == 2) ? 3'b100 : 3'b000);
        base3_s     = fn(bus3.vec, 0);
        bus3.f_in   = base3_s;
        bus3.sop_in = base3_s;
        bus3.pos_in = base3_s;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // starts a sweep on the SETTLE=1 instance; optionally re-pulses start at cycle start_at
    task automatic run1(input int start_at, output int cyc);
        bus1.start = 1'b1;
        tick();
        n_checks++;
        if (bus1.busy !== 1'b1 || bus1.vec !== 4'd0)
            $display("FAIL start_accept: busy=%0b vec=%0d expected busy=1 vec=0", bus1.busy, bus1.vec);
        else n_pass++;
        bus1.start = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 200; n++) begin
            bus1.start = (n == start_at);
            tick();
            if (bus1.done === 1'b1) begin
                cyc = n;
                break;
            end
        end
        bus1.start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.pass !== 1'b0)
            $display("FAIL reset_flags: busy=%0b done=%0b pass=%0b expected 0 0 0", bus1.busy, bus1.done, bus1.pass);
        else n_pass++;
        n_checks++;
        if (bus1.vec !== 4'd0 || bus1.err_count !== 5'd0 || bus1.first_err_valid !== 1'b0 || bus1.tt_out !== 48'h0)
            $display("FAIL reset_values: vec=%0d err=%0d fev_valid=%0b tt=%0h expected all 0",
                     bus1.vec, bus1.err_count, bus1.first_err_valid, bus1.tt_out);
        else n_pass++;
    endtask

    task automatic test_clean_sweep();
        int cyc;
        mode = 0;
        run1(0, cyc);
        n_checks++;
        if (cyc !== 32) $display("FAIL clean_latency: got %0d cycles expected 32", cyc); else n_pass++;
        n_checks++;
        if (bus1.pass !== 1'b1 || bus1.err_count !== 5'd0 || bus1.first_err_valid !== 1'b0)
            $display("FAIL clean_result: pass=%0b err=%0d fev_valid=%0b expected 1 0 0",
                     bus1.pass, bus1.err_count, bus1.first_err_valid);
        else n_pass++;
        n_checks++;
        if (bus1.vec !== 4'd15) $display("FAIL clean_vec_end: got %0d expected 15", bus1.vec); else n_pass++;
        n_checks++;
        if (bus1.tt_out !== tt_clean_exp)
            $display("FAIL clean_tt: got %0h expected %0h", bus1.tt_out, tt_clean_exp);
        else n_pass++;
        tick();
        n_checks++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.pass !== 1'b1 || bus1.vec !== 4'd15)
            $display("FAIL done_pulse: done=%0b busy=%0b pass=%0b vec=%0d expected 0 0 1 15",
                     bus1.done, bus1.busy, bus1.pass, bus1.vec);
        else n_pass++;
    endtask

    task automatic test_single_error();
        int cyc;
        mode = 1;
        run1(0, cyc);
        n_checks++;
        if (cyc !== 32) $display("FAIL single_latency: got %0d expected 32", cyc); else n_pass++;
        n_checks++;
        if (bus1.err_count !== 5'd1 || bus1.first_err_vec !== 4'd5 || bus1.first_err_valid !== 1'b1 || bus1.pass !== 1'b0)
            $display("FAIL single_error: err=%0d fev=%0d valid=%0b pass=%0b expected 1 5 1 0",
                     bus1.err_count, bus1.first_err_vec, bus1.first_err_valid, bus1.pass);
        else n_pass++;
    endtask

    task automatic test_all_error();
        int cyc;
        mode = 2;
        run1(0, cyc);
        n_checks++;
        if (cyc !== 32) $display("FAIL all_latency: got %0d expected 32", cyc); else n_pass++;
        n_checks++;
        if (bus1.err_count !== 5'd16 || bus1.first_err_vec !== 4'd0 || bus1.first_err_valid !== 1'b1 || bus1.pass !== 1'b0)
            $display("FAIL all_error: err=%0d fev=%0d valid=%0b pass=%0b expected 16 0 1 0",
                     bus1.err_count, bus1.first_err_vec, bus1.first_err_valid, bus1.pass);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int  cyc;
        logic seen;
        mode = 2;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus1.vec == 4'd7) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (seen !== 1'b1 || bus1.err_count === 5'd0)
            $display("FAIL mid_reach_vec7: seen=%0b err=%0d expected seen=1 err>0", seen, bus1.err_count);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.vec !== 4'd0 || bus1.err_count !== 5'd0 || bus1.first_err_valid !== 1'b0)
            $display("FAIL mid_reset: busy=%0b vec=%0d err=%0d valid=%0b expected 0 0 0 0",
                     bus1.busy, bus1.vec, bus1.err_count, bus1.first_err_valid);
        else n_pass++;
        mode = 0;
        run1(0, cyc);
        n_checks++;
        if (cyc !== 32 || bus1.pass !== 1'b1)
            $display("FAIL after_reset_sweep: cycles=%0d pass=%0b expected 32 1", cyc, bus1.pass);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int cyc;
        mode = 0;
        run1(10, cyc);
        n_checks++;
        if (cyc !== 32 || bus1.pass !== 1'b1)
            $display("FAIL start_ignored: cycles=%0d pass=%0b expected 32 1", cyc, bus1.pass);
        else n_pass++;
        tick();
        n_checks++;
        if (bus1.busy !== 1'b0) $display("FAIL no_queued_start: busy=%0b expected 0", bus1.busy); else n_pass++;
    endtask

    task automatic test_settle3();
        int cyc;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (bus3.done === 1'b1) begin
                cyc = n;
                break;
            end
        end
        n_checks++;
        if (cyc !== 64) $display("FAIL settle3_latency: got %0d expected 64", cyc); else n_pass++;
        n_checks++;
        if (bus3.pass !== 1'b1 || bus3.vec !== 4'd15 || bus3.err_count !== 5'd0)
            $display("FAIL settle3_result: pass=%0b vec=%0d err=%0d expected 1 15 0", bus3.pass, bus3.vec, bus3.err_count);
        else n_pass++;
    endtask

    task automatic test_capture();
        int cyc;
        logic [15:0] exp_f;
`ifdef TT_CAPTURE_EN
        exp_f = 16'h6996;
`else
        exp_f = 16'h0000;
`endif
        mode = 3;
        run1(0, cyc);
        n_checks++;
        if (bus1.tt_out[15:0] !== exp_f || bus1.pass !== 1'b1)
            $display("FAIL capture_parity: tt_f=%0h pass=%0b expected %0h 1", bus1.tt_out[15:0], bus1.pass, exp_f);
        else n_pass++;
    endtask

    initial begin
`ifdef TT_CAPTURE_EN
        tt_clean_exp = {16'h5A5A, 16'hFFCC, 16'hF000};
`else
        tt_clean_exp = 48'h0;
`endif
        reset      = 1'b1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_clean_sweep();
        test_single_error();
        test_all_error();
        test_reset_mid_sweep();
        test_start_ignored();
        test_settle3();
        test_capture();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
